register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//  Architectural register bank of the 5-stage MIPS pipeline. Receiver of the write-back stage:
//  takes the selected result (write data, destination register, write enable) and stores it.
//  Serves two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
//  Provides a debug dump sequencer that streams all registers to the debug/UART unit on request.
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  5   register index width; NREGS = 2**ADDR_W
// PORTS
//  clk        in   1       pipeline clock, all state updates on rising edge
//  rst        in   1       asynchronous, active-high reset
//  wr_en      in   1       write strobe from write-back stage (RegWrite)
//  wr_addr    in   ADDR_W  destination register index from write-back
//  wr_data    in   DATA_W  write-back result (data_out of write_back)
//  rd_addr_a  in   ADDR_W  decode read index rs
//  rd_addr_b  in   ADDR_W  decode read index rt
//  rd_data_a  out  DATA_W  value of rs
//  rd_data_b  out  DATA_W  value of rt
//  dump_req   in   1       debug: start full register dump (pulse or level)
//  dump_ready in   1       debug sink can accept a word this cycle
//  dump_valid out  1       dump_data/dump_idx hold a word
//  dump_idx   out  ADDR_W  index of register on dump_data
//  dump_data  out  DATA_W  register contents being dumped
//  dump_busy  out  1       dump sequence in progress
//  dump_done  out  1       one-cycle pulse after last word accepted
// BEHAVIOUR
//  - Reset: all NREGS registers = 0; FSM = IDLE; dump_valid=0, dump_idx=0, dump_busy=0, dump_done=0.
//  - Write: on posedge clk with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data. Writes to r0 ignored.
//  - Read: combinational. rd_addr==0 -> 0. Else if wr_en && wr_addr==rd_addr -> wr_data (bypass,
//    so decode sees value written in same cycle). Else regs[rd_addr]. Ports a/b independent.
//  - Dump FSM states: IDLE, SEND, DONE.
//    IDLE: dump_req=1 -> SEND, dump_idx<=0. dump_busy=1 in SEND only.
//    SEND: dump_valid=1; dump_data = regs[dump_idx] using same bypass rule as read ports.
//      Word transferred when dump_valid && dump_ready. Then dump_idx<=dump_idx+1; if dump_idx==NREGS-1 -> DONE.
//      dump_ready=0 holds dump_idx; dump_data may change only via a write to that register.
//    DONE: dump_done=1 for exactly one cycle, dump_idx<=0, -> IDLE. dump_req ignored outside IDLE;
//      a level-held dump_req restarts a new dump from IDLE on the following cycle.
//  - Writes continue normally during a dump; the dump never stalls the pipeline.
//  - dump_idx increments without wrap beyond NREGS-1 (counter sized ADDR_W; terminal check precedes increment).
//  - Reset mid-dump: immediate return to IDLE, outputs to reset values; no dump_done pulse.
//  - Latency: write visible to reads same cycle (bypass) and from register array next cycle.
// STRUCTURE
//  - Shared package/include: DATA_W, ADDR_W defaults, REG_ZERO=0, dump FSM state encodings.
//  - Single module; the dump FSM is small enough to stay inline, no sub-module.
// TESTING
//  1 Reset: rst=1 mid-run -> rd_data_a/b=0 for all addrs, dump_valid=0, dump_busy=0.
//  2 Write/read: wr_en=1, wr_addr=8, wr_data=5; next cycle rd_addr_a=8 -> 5; rd_addr_b=0 -> 0.
//  3 r0 write: wr_en=1, wr_addr=0, wr_data=32'hDEADBEEF -> rd_addr_a=0 still returns 0.
//  4 Bypass: same cycle wr_en=1, wr_addr=3, wr_data=7, rd_addr_a=3 -> rd_data_a=7 before the edge.
//  5 Dump: regs[i]=i*4, dump_req pulse, dump_ready=1 -> 32 words idx 0..31, data 0..124, then dump_done pulse, busy=0.
//  6 Dump backpressure+reset: dump_ready toggled 1/0 -> idx holds on 0; rst at idx=10 -> IDLE, no dump_done.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared definitions for the architectural register bank: default widths,
// the hard-wired zero register index and the debug dump sequencer states.
package register_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/register_file.sv
// MIPS architectural register bank: two combinational read ports with write bypass,
// one write port from write-back, and a valid/ready debug dump sequencer.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              dump_req,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    logic [DATA_W-1:0] regs [NREGS];
    dump_state_t       state, state_nxt;
    logic [ADDR_W-1:0] idx_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != ZERO_IDX) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Same-cycle bypass lets decode see the value write-back is committing now.
    assign rd_data_a = (rd_addr_a == ZERO_IDX) ? '0 :
                       (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == ZERO_IDX) ? '0 :
                       (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
    assign dump_data = (dump_idx == ZERO_IDX) ? '0 :
                       (wr_en && wr_addr == dump_idx) ? wr_data : regs[dump_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            dump_idx <= '0;
        end else begin
            state    <= state_nxt;
            dump_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = dump_idx;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dump_req) begin
                    state_nxt = ST_SEND;
                    idx_nxt   = '0;
                end
            end
            ST_SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    // Terminal check before increment: the index never wraps.
                    if (dump_idx == LAST_IDX) state_nxt = ST_DONE;
                    else                      idx_nxt   = dump_idx + 1'b1;
                end
            end
            ST_DONE: begin
                dump_done = 1'b1;
                idx_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a behavioural register/dump model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        dump_req, dump_ready;
    logic        dump_valid;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_busy, dump_done;

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .dump_req(dump_req), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents plus "which word is being offered".
    logic [31:0] m_regs [32];
    bit          m_active;
    bit          m_done;
    int          m_next;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_active = 0; m_done = 0; m_next = 0;
        end else begin
            if (m_done) begin
                m_done = 0;
            end else if (m_active) begin
                if (dump_ready) begin
                    if (m_next == 31) begin
                        m_active = 0;
                        m_done   = 1;
                    end else begin
                        m_next++;
                    end
                end
            end else if (dump_req) begin
                m_active = 1;
                m_next   = 0;
            end
            if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
        end
    end

    logic [4:0]  cap_idx  [$];
    logic [31:0] cap_data [$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        check("rd_data_a", rd_data_a, m_read(rd_addr_a));
        check("rd_data_b", rd_data_b, m_read(rd_addr_b));
        check("dump_valid", {31'd0, dump_valid}, {31'd0, m_active});
        check("dump_busy", {31'd0, dump_busy}, {31'd0, m_active});
        check("dump_done", {31'd0, dump_done}, {31'd0, m_done});
        if (m_active) begin
            check("dump_idx", {27'd0, dump_idx}, m_next);
            check("dump_data", dump_data, m_read(5'(m_next)));
        end else if (!m_done) begin
            check("dump_idx_idle", {27'd0, dump_idx}, 32'd0);
        end
        if (!rst && dump_valid && dump_ready) begin
            cap_idx.push_back(dump_idx);
            cap_data.push_back(dump_data);
        end
        if (!rst && dump_done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!dump_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {31'd0, dump_done}, 32'd1);
    endtask

    initial begin
        int base;
        rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_addr_a = 0; rd_addr_b = 0; dump_req = 0; dump_ready = 0;
        repeat (3) step();
        rst = 0;
        step();
        check("reset_busy", {31'd0, dump_busy}, 32'd0);

        // Write then read next cycle
        wr_en = 1; wr_addr = 5'd8; wr_data = 32'd5;
        step();
        wr_en = 0; rd_addr_a = 5'd8; rd_addr_b = 5'd0;
        @(negedge clk);
        check("wr_rd_a", rd_data_a, 32'd5);
        check("wr_rd_b_r0", rd_data_b, 32'd0);

        // r0 is hard-wired to zero
        step();
        wr_en = 1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
        step();
        wr_en = 0; rd_addr_a = 5'd0;
        @(negedge clk);
        check("r0_write", rd_data_a, 32'd0);

        // Same-cycle bypass on both ports
        step();
        wr_en = 1; wr_addr = 5'd3; wr_data = 32'd7; rd_addr_a = 5'd3; rd_addr_b = 5'd3;
        @(negedge clk);
        check("bypass_a", rd_data_a, 32'd7);
        check("bypass_b", rd_data_b, 32'd7);

        // Full dump with regs[i] = i*4
        for (int i = 1; i < 32; i++) begin
            step();
            wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i * 4);
        end
        step();
        wr_en = 0; dump_ready = 1; dump_req = 1;
        cap_idx.delete(); cap_data.delete();
        base = done_cnt;
        step();
        dump_req = 0;
        wait_done("dump1");
        step();
        check("dump1_words", cap_idx.size(), 32'd32);
        for (int i = 0; i < 32 && i < cap_idx.size(); i++) begin
            check("dump1_idx", {27'd0, cap_idx[i]}, i);
            check("dump1_data", cap_data[i], 32'(i * 4));
        end
        check("dump1_done_cnt", done_cnt - base, 32'd1);
        check("dump1_busy_after", {31'd0, dump_busy}, 32'd0);
        check("dump1_w31", cap_data.size() == 32 ? cap_data[31] : 32'hx, 32'd124);

        // Backpressure then reset mid-dump
        cap_idx.delete(); cap_data.delete();
        dump_ready = 0; dump_req = 1;
        step();
        dump_req = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_idx_hold", {27'd0, dump_idx}, 32'd0);
            check("bp_valid", {31'd0, dump_valid}, 32'd1);
            step();
        end
        base = done_cnt;
        for (int n = 0; n < 100 && cap_idx.size() < 10; n++) begin
            dump_ready = ~dump_ready;
            step();
        end
        dump_ready = 0;
        check("pre_rst_idx", {27'd0, dump_idx}, 32'd10);
        rst = 1;
        #1;
        check("rst_valid", {31'd0, dump_valid}, 32'd0);
        check("rst_busy", {31'd0, dump_busy}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
            #1;
            check("rst_rd_a", rd_data_a, 32'd0);
            check("rst_rd_b", rd_data_b, 32'd0);
        end
        step();
        rst = 0;
        repeat (4) step();
        check("rst_no_done", done_cnt - base, 32'd0);

        // Level-held request restarts from IDLE after DONE
        for (int i = 1; i < 32; i++) begin
            step();
            wr_en = 1; wr_addr = 5'(i); wr_data = 32'h100 + 32'(i);
        end
        step();
        wr_en = 0; dump_ready = 1; dump_req = 1;
        @(negedge clk);
        wait_done("dump2");
        @(negedge clk);
        check("restart_idle", {31'd0, dump_busy}, 32'd0);
        @(negedge clk);
        check("restart_busy", {31'd0, dump_busy}, 32'd1);
        check("restart_idx", {27'd0, dump_idx}, 32'd0);
        step();
        dump_req = 0;
        // Write during the dump: the word for r20 must show the new value
        wr_en = 1; wr_addr = 5'd20; wr_data = 32'hCAFE0014;
        step();
        wr_en = 0;
        wait_done("dump3");
        step();
        check("dump3_busy_after", {31'd0, dump_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
